pixel_stream_tx: RTL and testbench
==================================

# pixel_stream_tx

Frame source for the median preparation path: it drives the `data_i`/`done_i` pixel stream consumed by `Buffer_16_rows`. It accepts interior pixels from upstream with a valid/ready handshake and emits them in raster order. Each frame is wrapped in a border of `PAD` constant-valued pixels on all four sides, so the 17-row window sees a fully padded image. Downstream has no backpressure; upstream stalls only gap interior beats.

## Interface
- `COLS`, 256, interior image width in pixels
- `ROWS`, 256, interior image height in pixels
- `PAD`, 8, border width on each side (window half-size); `COLS+2*PAD` must equal the line-buffer row length
- `DATA_W`, 8, pixel width
- `PAD_VAL`, 0, value emitted for border pixels

Ports:
- `clk`  in  1  system clock; all logic on rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `start_i`  in  1  one-cycle frame start request
- `pix_valid_i`  in  1  upstream interior pixel valid
- `pix_i`  in  DATA_W  upstream interior pixel
- `pix_ready_o`  out  1  interior pixel accepted this cycle when high with `pix_valid_i`
- `data_o`  out  DATA_W  pixel to line buffer (its `data_i`)
- `done_o`  out  1  `data_o` valid this cycle (its `done_i`)
- `busy_o`  out  1  frame in progress
- `frame_done_o`  out  1  one-cycle pulse on the final beat of a frame

## Operation
- Padded frame: `PR = ROWS+2*PAD` rows by `PC = COLS+2*PAD` columns, scanned in raster order. Column counter `col` runs 0..PC-1 and row counter `row` runs 0..PR-1. Counter width is `$clog2` of the max.
- Interior position: `PAD <= row < PAD+ROWS` and `PAD <= col < PAD+COLS`. All other positions are border.
- FSM states:
  - IDLE: `start_i` loads row=col=0 and moves to BORDER if (0,0) is border, otherwise to PIX. With `PAD=0`, (0,0) is interior.
  - BORDER: one beat per cycle with `data_o=PAD_VAL` and `done_o=1`, then the position advances.
  - PIX: `pix_ready_o=1`. A transfer (`pix_valid_i && pix_ready_o`) emits `pix_i` and advances the position. With no transfer, `done_o=0` and the position holds.
  - After each advance, the next state is BORDER or PIX according to the new position. Advancing past (PR-1, PC-1) returns to IDLE.
- `col` wraps from PC-1 to 0 and increments `row`.
- `start_i` while busy is ignored. `start_i` on the same cycle as the final beat is also ignored; a new frame needs `start_i` while in IDLE.
- `pix_ready_o` is combinational from state: high only in PIX. It never depends on `pix_valid_i`.
- Beats per frame on `done_o` = PR*PC exactly. Interior transfers = ROWS*COLS exactly.
- Reset mid-frame: state goes to IDLE, counters clear, all outputs go low immediately. The partial frame is abandoned and no `frame_done_o` is issued.

## Timing
- Reset values: `data_o=0`, `done_o=0`, `busy_o=0`, `frame_done_o=0`, `pix_ready_o=0`.
- `data_o`, `done_o` and `frame_done_o` are registered; they appear the cycle after the beat's decision (border step or transfer).
- `start_i` at cycle t puts the first beat on `done_o` at t+2: state update at t+1, registered output at t+2.
- `busy_o` is high from the cycle after `start_i` through the cycle carrying the final beat.
- `frame_done_o` is coincident with the final `done_o` beat. `busy_o` falls the next cycle.
- With upstream always valid, `done_o` stays high for PR*PC consecutive cycles.

## Structure
- Shared package/header: FSM state encodings (IDLE, BORDER, PIX) and the default `PAD_VAL`. The `PR`/`PC` derivations are computed locally as localparams.
- One sub-module: `raster_counter`, the parameterised row/col counter with `advance`, `clear`, wrap, and `last` flag. The top level holds the FSM, the interior decode and the output registers.

## Test plan
Parameters for all scenarios: COLS=3, ROWS=2, PAD=1, PAD_VAL=0; upstream pixels 1..6.

1. Reset then idle, with `start_i` never asserted -> all outputs 0, no `done_o`, `pix_ready_o` stays 0.
2. `start_i` with `pix_valid_i` held high -> 20 consecutive beats: 0 0 0 0 0 | 0 1 2 3 0 | 0 4 5 6 0 | 0 0 0 0 0. `frame_done_o` on beat 20; `busy_o` falls the next cycle.
3. Same frame with `pix_valid_i` low for 3 cycles before pixel 5 -> `done_o` gaps for exactly 3 cycles; beat sequence unchanged; 20 beats total.
4. `start_i` pulsed again mid-frame -> ignored; exactly one 20-beat frame and one `frame_done_o`.
5. `rst` low after beat 8, then released, then `start_i` -> outputs 0 immediately on reset; next frame begins from the top-left 0 and upstream resends from pixel 1.
6. PAD=0, COLS=2, ROWS=2 -> 4 beats 1 2 3 4 with no border beats; `pix_ready_o` high from the first cycle after `start_i`.

Source files
------------

// File: rtl/pixel_stream_tx_pkg.sv
// rtl/pixel_stream_tx_pkg.sv - FSM encodings, defaults and small helpers for the padded pixel source
package pixel_stream_tx_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_BORDER = 2'd1;
  localparam logic [1:0] ST_PIX    = 2'd2;

  localparam int PAD_VAL_DEFAULT = 0;

  // Counters never shrink below one bit so degenerate 1-wide frames still elaborate.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic in_band(input int pos, input int lo, input int len);
    return (pos >= lo) && (pos < lo + len);
  endfunction

endpackage

// File: rtl/pixel_stream_tx_if.sv
// rtl/pixel_stream_tx_if.sv - upstream pixel handshake, line-buffer stream and frame status bundle
interface pixel_stream_tx_if #(
  parameter int DATA_W = 8
);
  logic              start_i;
  logic              pix_valid_i;
  logic [DATA_W-1:0] pix_i;
  logic              pix_ready_o;
  logic [DATA_W-1:0] data_o;
  logic              done_o;
  logic              busy_o;
  logic              frame_done_o;

  modport slave (
    input  start_i, pix_valid_i, pix_i,
    output pix_ready_o, data_o, done_o, busy_o, frame_done_o
  );

  modport master (
    output start_i, pix_valid_i, pix_i,
    input  pix_ready_o, data_o, done_o, busy_o, frame_done_o
  );
endinterface

// File: rtl/pixel_stream_tx_raster_counter.sv
// rtl/pixel_stream_tx_raster_counter.sv - raster row/col position counter with wrap and last-position flag
module raster_counter
  import pixel_stream_tx_pkg::*;
#(
  parameter int PR = 18,
  parameter int PC = 18,
  localparam int RW = cnt_width(PR),
  localparam int CW = cnt_width(PC)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          advance,
  output logic [RW-1:0] next_row,
  output logic [CW-1:0] next_col,
  output logic          last
);

  localparam logic [RW-1:0] ROW_LAST = RW'(PR - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(PC - 1);

  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic          col_wrap;

  assign col_wrap = (col == COL_LAST);
  assign last     = col_wrap && (row == ROW_LAST);

  // next_* is the position after an advance; the top decodes it to pick the next state.
  always_comb begin
    next_col = col_wrap ? '0 : col + 1'b1;
    next_row = row;
    if (col_wrap) begin
      next_row = (row == ROW_LAST) ? '0 : row + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row <= '0;
      col <= '0;
    end else if (clear) begin
      row <= '0;
      col <= '0;
    end else if (advance) begin
      row <= next_row;
      col <= next_col;
    end
  end

endmodule

// File: rtl/pixel_stream_tx.sv
// rtl/pixel_stream_tx.sv - emits interior pixels in raster order wrapped in a constant PAD-wide border
module pixel_stream_tx
  import pixel_stream_tx_pkg::*;
#(
  parameter int                COLS    = 256,
  parameter int                ROWS    = 256,
  parameter int                PAD     = 8,
  parameter int                DATA_W  = 8,
  parameter logic [DATA_W-1:0] PAD_VAL = DATA_W'(PAD_VAL_DEFAULT)
) (
  input  logic               clk,
  input  logic               rst,
  pixel_stream_tx_if.slave   bus
);

  localparam int PR = ROWS + 2 * PAD;
  localparam int PC = COLS + 2 * PAD;
  localparam int RW = cnt_width(PR);
  localparam int CW = cnt_width(PC);

  logic [1:0]        state;
  logic [1:0]        state_nx;
  logic [RW-1:0]     next_row;
  logic [CW-1:0]     next_col;
  logic              last;
  logic              start_ok;
  logic              beat;
  logic [DATA_W-1:0] beat_data;

  function automatic logic interior(input int r, input int c);
    return in_band(r, PAD, ROWS) && in_band(c, PAD, COLS);
  endfunction

  // busy_o is still high on the final-beat cycle, so a start there is dropped.
  assign start_ok = (state == ST_IDLE) && bus.start_i && !bus.frame_done_o;

  raster_counter #(
    .PR (PR),
    .PC (PC)
  ) u_raster_counter (
    .clk      (clk),
    .rst      (rst),
    .clear    (start_ok),
    .advance  (beat),
    .next_row (next_row),
    .next_col (next_col),
    .last     (last)
  );

  always_comb begin
    beat      = 1'b0;
    beat_data = PAD_VAL;
    state_nx  = state;
    case (state)
      ST_IDLE: begin
        if (start_ok) begin
          state_nx = interior(0, 0) ? ST_PIX : ST_BORDER;
        end
      end
      ST_BORDER: beat = 1'b1;
      ST_PIX: begin
        beat      = bus.pix_valid_i;
        beat_data = bus.pix_i;
      end
      default: state_nx = ST_IDLE;
    endcase
    if (beat) begin
      if (last) begin
        state_nx = ST_IDLE;
      end else begin
        state_nx = interior(int'(next_row), int'(next_col)) ? ST_PIX : ST_BORDER;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state            <= ST_IDLE;
      bus.data_o       <= '0;
      bus.done_o       <= 1'b0;
      bus.frame_done_o <= 1'b0;
    end else begin
      state            <= state_nx;
      bus.data_o       <= beat ? beat_data : '0;
      bus.done_o       <= beat;
      bus.frame_done_o <= beat && last;
    end
  end

  assign bus.pix_ready_o = (state == ST_PIX);
  assign bus.busy_o      = (state != ST_IDLE) || bus.frame_done_o;

endmodule

// File: tb/tb_pixel_stream_tx.sv
// tb/tb_pixel_stream_tx.sv - self-checking bench for pixel_stream_tx
module tb_pixel_stream_tx;

  localparam int COLS  = 3;
  localparam int ROWS  = 2;
  localparam int PAD   = 1;
  localparam int PR    = ROWS + 2 * PAD;
  localparam int PC    = COLS + 2 * PAD;
  localparam int NBEAT = PR * PC;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pixel_stream_tx_if #(.DATA_W(8)) bus_a ();
  pixel_stream_tx_if #(.DATA_W(8)) bus_b ();

  pixel_stream_tx #(
    .COLS(COLS), .ROWS(ROWS), .PAD(PAD), .DATA_W(8), .PAD_VAL(8'd0)
  ) dut_a (
    .clk(clk), .rst(rst_n), .bus(bus_a.slave)
  );

  pixel_stream_tx #(
    .COLS(2), .ROWS(2), .PAD(0), .DATA_W(8), .PAD_VAL(8'd0)
  ) dut_b (
    .clk(clk), .rst(rst_n), .bus(bus_b.slave)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  int   exp_q[$];
  int   beats = 0, frames = 0, cyc = 0, first_cyc = -1, fd_cyc = -1;
  logic fd_prev = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      fd_prev = 1'b0;
    end else begin
      if (fd_prev) chk("busy_after_frame_done", int'(bus_a.busy_o), 0);
      if (bus_a.done_o) begin
        beats++;
        if (first_cyc < 0) first_cyc = cyc;
        chk("busy_during_beat", int'(bus_a.busy_o), 1);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got data %0d expected no beat", bus_a.data_o);
        end else begin
          chk($sformatf("beat%0d_data", beats), int'(bus_a.data_o), exp_q.pop_front());
        end
      end
      if (bus_a.frame_done_o) begin
        frames++;
        fd_cyc = cyc;
        chk("frame_done_pending_beats", exp_q.size(), 0);
        chk("frame_done_with_done", int'(bus_a.done_o), 1);
      end
      fd_prev = bus_a.frame_done_o;
    end
  end

  task automatic run_frame(input int gap_pix, input int gap_len, input int restart_at,
                           input int abort_beats, output int start_cyc, output int timed_out);
    int   next_pix = 1;
    int   gap_done = 0;
    logic xfer = 1'b0;
    logic v;
    for (int r = 0; r < PR; r++)
      for (int c = 0; c < PC; c++)
        exp_q.push_back((r >= PAD && r < PAD + ROWS && c >= PAD && c < PAD + COLS)
                        ? (r - PAD) * COLS + (c - PAD) + 1 : 0);
    beats = 0; frames = 0; first_cyc = -1; fd_cyc = -1;
    @(posedge clk); #2;
    bus_a.start_i = 1'b1;
    start_cyc = cyc;
    timed_out = 1;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #2;
      bus_a.start_i = (i == restart_at);
      if (xfer) next_pix++;
      if (abort_beats > 0 && beats >= abort_beats) begin timed_out = 0; break; end
      if (frames > 0 && cyc > fd_cyc + 2) begin timed_out = 0; break; end
      v = !(next_pix == gap_pix && gap_done < gap_len);
      if (!v && bus_a.pix_ready_o) gap_done++;
      bus_a.pix_valid_i = v;
      bus_a.pix_i = 8'(next_pix);
      xfer = v && bus_a.pix_ready_o;
    end
    bus_a.start_i = 1'b0;
    bus_a.pix_valid_i = 1'b0;
  endtask

  typedef struct {
    string name;
    int    gap_pix;
    int    gap_len;
    int    restart_at;
    int    exp_beats;
    int    exp_frames;
    int    exp_span;
  } vec_t;

  vec_t tbl[3];
  int   sc, to;

  initial begin
    tbl[0] = '{name: "full",    gap_pix: -1, gap_len: 0, restart_at: -1, exp_beats: NBEAT, exp_frames: 1, exp_span: NBEAT};
    tbl[1] = '{name: "gap3",    gap_pix: 5,  gap_len: 3, restart_at: -1, exp_beats: NBEAT, exp_frames: 1, exp_span: NBEAT + 3};
    tbl[2] = '{name: "restart", gap_pix: -1, gap_len: 0, restart_at: 6,  exp_beats: NBEAT, exp_frames: 1, exp_span: NBEAT};

    bus_a.start_i = 1'b0; bus_a.pix_valid_i = 1'b0; bus_a.pix_i = '0;
    bus_b.start_i = 1'b0; bus_b.pix_valid_i = 1'b0; bus_b.pix_i = '0;

    repeat (3) @(posedge clk);
    #2;
    chk("rst_data", int'(bus_a.data_o), 0);
    chk("rst_done", int'(bus_a.done_o), 0);
    chk("rst_busy", int'(bus_a.busy_o), 0);
    chk("rst_frame_done", int'(bus_a.frame_done_o), 0);
    chk("rst_ready", int'(bus_a.pix_ready_o), 0);
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #2;
    chk("idle_done", int'(bus_a.done_o), 0);
    chk("idle_busy", int'(bus_a.busy_o), 0);
    chk("idle_ready", int'(bus_a.pix_ready_o), 0);
    chk("idle_beats", beats, 0);

    foreach (tbl[k]) begin
      run_frame(tbl[k].gap_pix, tbl[k].gap_len, tbl[k].restart_at, 0, sc, to);
      chk({tbl[k].name, "_timeout"}, to, 0);
      chk({tbl[k].name, "_beats"}, beats, tbl[k].exp_beats);
      chk({tbl[k].name, "_frames"}, frames, tbl[k].exp_frames);
      chk({tbl[k].name, "_span"}, fd_cyc - first_cyc + 1, tbl[k].exp_span);
      chk({tbl[k].name, "_latency"}, first_cyc - sc, 3);
      chk({tbl[k].name, "_leftover"}, exp_q.size(), 0);
      repeat (3) @(posedge clk);
    end

    // Reset after beat 8 abandons the frame; the next one restarts from the corner.
    run_frame(-1, 0, -1, 8, sc, to);
    chk("abort_timeout", to, 0);
    rst_n = 1'b0;
    #1;
    chk("abort_done", int'(bus_a.done_o), 0);
    chk("abort_data", int'(bus_a.data_o), 0);
    chk("abort_busy", int'(bus_a.busy_o), 0);
    chk("abort_ready", int'(bus_a.pix_ready_o), 0);
    chk("abort_frame_done", int'(bus_a.frame_done_o), 0);
    chk("abort_no_frame", frames, 0);
    exp_q.delete();
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    run_frame(-1, 0, -1, 0, sc, to);
    chk("after_rst_timeout", to, 0);
    chk("after_rst_beats", beats, NBEAT);
    chk("after_rst_frames", frames, 1);
    chk("after_rst_latency", first_cyc - sc, 3);

    // PAD=0 instance: no border beats, ready the cycle after start.
    @(posedge clk); #2;
    bus_b.start_i = 1'b1; bus_b.pix_valid_i = 1'b1; bus_b.pix_i = 8'd1;
    @(posedge clk); #2;
    bus_b.start_i = 1'b0;
    chk("b_ready_first", int'(bus_b.pix_ready_o), 1);
    chk("b_no_beat_yet", int'(bus_b.done_o), 0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #2;
      chk($sformatf("b_beat%0d_done", i + 1), int'(bus_b.done_o), 1);
      chk($sformatf("b_beat%0d_data", i + 1), int'(bus_b.data_o), i + 1);
      chk($sformatf("b_beat%0d_frame_done", i + 1), int'(bus_b.frame_done_o), (i == 3) ? 1 : 0);
      bus_b.pix_i = 8'(i + 2);
    end
    bus_b.pix_valid_i = 1'b0;
    @(posedge clk); #2;
    chk("b_busy_end", int'(bus_b.busy_o), 0);
    chk("b_done_end", int'(bus_b.done_o), 0);
    chk("b_ready_end", int'(bus_b.pix_ready_o), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
